// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB mixer PWM channels.
// Holds the default width/prescaler and the channel state encoding.
package rgb_pkg;

  localparam int PWM_WIDTH = 8;
  localparam int PWM_DIV   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } pwm_state_t;

  // Prescaler register width; never below one bit.
  function automatic int pre_bits(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick is high once every DIV cycles while run is set.
// Ports: clk, reset (sync, active-high), clear, run -> tick.
module pwm_prescaler
  import rgb_pkg::*;
#(
  parameter int DIV = PWM_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PW = pre_bits(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  assign tick = run && (pre == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre <= '0;
    end else if (run) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// One PWM colour channel: double-buffered duty, graceful stop.
// Ports: clk, reset, enable, duty -> pwm_out, period_start, busy.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int DIV   = PWM_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  pwm_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic             tick;
  logic             wrap;
  logic             clr;

  assign busy = (state != ST_IDLE);
  assign wrap = tick && (cnt == CNT_MAX);

  // Prescaler is held at zero in IDLE and when a stop completes.
  assign clr = (state == ST_IDLE) ||
               ((state == ST_STOP) && wrap && !enable);

  pwm_prescaler #(
    .DIV(DIV)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clear(clr),
    .run  (busy),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      duty_q       <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      pwm_out      <= busy && (cnt < duty_q);
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (enable) begin
            state        <= ST_RUN;
            duty_q       <= duty;
            period_start <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) cnt <= cnt + 1'b1;
          // Shadow load only at the wrap: no runt pulses.
          if (wrap) begin
            duty_q       <= duty;
            period_start <= 1'b1;
          end
          if (!enable) state <= ST_STOP;
        end
        ST_STOP: begin
          if (tick) cnt <= cnt + 1'b1;
          if (enable) begin
            state <= ST_RUN;
            if (wrap) begin
              duty_q       <= duty;
              period_start <= 1'b1;
            end
          end else if (wrap) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_channel.sv
// Bench for pwm_channel: WIDTH=4 with DIV=1 and DIV=2 side by side.
// Directed table, hand sequences and random traffic vs a period model.
module tb_pwm_channel;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] duty = '0;

  logic pwm_a, ps_a, busy_a;
  logic pwm_b, ps_b, busy_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_channel #(.WIDTH(4), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty),
    .pwm_out(pwm_a), .period_start(ps_a), .busy(busy_a)
  );

  pwm_channel #(.WIDTH(4), .DIV(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty),
    .pwm_out(pwm_b), .period_start(ps_b), .busy(busy_b)
  );

  // Model: mode 0 idle, 1 running, 2 stopping.
  // t = clocks elapsed since the period began.
  int   m_mode[2];
  int   m_t[2];
  int   m_dq[2];
  logic m_pwm[2];
  logic m_ps[2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int   d;
    int   plen;
    logic pn;
    d    = div_of(i);
    plen = 16 * d;
    if (reset) begin
      m_mode[i] = 0; m_t[i] = 0; m_dq[i] = 0;
      m_pwm[i] = 1'b0; m_ps[i] = 1'b0;
      return;
    end
    pn = (m_mode[i] != 0) && ((m_t[i] / d) < m_dq[i]);
    m_ps[i] = 1'b0;
    if (m_mode[i] == 0) begin
      m_t[i] = 0;
      if (enable) begin
        m_mode[i] = 1; m_dq[i] = int'(duty); m_ps[i] = 1'b1;
      end
    end else if (m_t[i] == plen - 1) begin
      m_t[i] = 0;
      if (m_mode[i] == 1 || enable) begin
        m_dq[i] = int'(duty);
        m_ps[i] = 1'b1;
        m_mode[i] = enable ? 1 : 2;
      end else begin
        m_mode[i] = 0;
      end
    end else begin
      m_t[i]++;
      m_mode[i] = enable ? 1 : 2;
    end
    m_pwm[i] = pn;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("a_pwm", 32'(pwm_a), 32'(m_pwm[0]));
    check("a_ps", 32'(ps_a), 32'(m_ps[0]));
    check("a_busy", 32'(busy_a), 32'(m_mode[0] != 0));
    check("b_pwm", 32'(pwm_b), 32'(m_pwm[1]));
    check("b_ps", 32'(ps_b), 32'(m_ps[1]));
    check("b_busy", 32'(busy_b), 32'(m_mode[1] != 0));
  endtask

  task automatic wait_ps(input int i);
    int n;
    n = 0;
    while (((i == 0) ? ps_a : ps_b) !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("wait_ps", 32'((i == 0) ? ps_a : ps_b), 32'd1);
  endtask

  task automatic count_high(input int i, input int n,
                            output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      step();
      highs += int'((i == 0) ? pwm_a : pwm_b);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    int   cyc;
    logic pwm;
    logic ps;
    logic busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int h;

    tbl[0]  = '{1,  1'b0, 1'b1, 1'b1};
    tbl[1]  = '{2,  1'b1, 1'b0, 1'b1};
    tbl[2]  = '{6,  1'b1, 1'b0, 1'b1};
    tbl[3]  = '{7,  1'b0, 1'b0, 1'b1};
    tbl[4]  = '{16, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{17, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{18, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{22, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{23, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{32, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{33, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_t[i] = 0; m_dq[i] = 0;
      m_pwm[i] = 1'b0; m_ps[i] = 1'b0;
    end

    // Reset state
    do_reset();
    check("rst_pwm", 32'(pwm_a), 32'd0);
    check("rst_ps", 32'(ps_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);

    // Basic waveform, DIV=1, duty=5
    enable = 1'b1;
    duty   = 4'd5;
    for (int c = 1; c <= 34; c++) begin
      step();
      foreach (tbl[r]) begin
        if (tbl[r].cyc == c) begin
          check($sformatf("tbl%0d_pwm", r), 32'(pwm_a), 32'(tbl[r].pwm));
          check($sformatf("tbl%0d_ps", r), 32'(ps_a), 32'(tbl[r].ps));
          check($sformatf("tbl%0d_busy", r), 32'(busy_a), 32'(tbl[r].busy));
        end
      end
    end

    // DIV=2 extremes: duty 0 then 15
    enable = 1'b0;
    do_reset();
    duty   = 4'd0;
    enable = 1'b1;
    wait_ps(1);
    duty = 4'd15;
    count_high(1, 32, h);
    check("div2_duty0", 32'(h), 32'd0);
    check("div2_ps", 32'(ps_b), 32'd1);
    count_high(1, 32, h);
    check("div2_duty15", 32'(h), 32'd30);

    // Shadow update at cnt=7
    enable = 1'b0;
    do_reset();
    duty   = 4'd3;
    enable = 1'b1;
    wait_ps(0);
    h = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      h += int'(pwm_a);
      if (k == 6) duty = 4'd12;
    end
    check("shadow_old", 32'(h), 32'd3);
    check("shadow_ps", 32'(ps_a), 32'd1);
    count_high(0, 16, h);
    check("shadow_new", 32'(h), 32'd12);

    // Graceful stop at cnt=4
    enable = 1'b0;
    do_reset();
    duty   = 4'd5;
    enable = 1'b1;
    wait_ps(0);
    repeat (4) step();
    enable = 1'b0;
    for (int k = 0; k < 11; k++) begin
      step();
      check("stop_busy", 32'(busy_a), 32'd1);
    end
    step();
    check("stop_idle_busy", 32'(busy_a), 32'd0);
    check("stop_idle_ps", 32'(ps_a), 32'd0);
    check("stop_idle_pwm", 32'(pwm_a), 32'd0);
    repeat (3) step();
    check("stop_idle_hold", 32'(busy_a), 32'd0);

    // Stop cancelled at cnt=10
    enable = 1'b1;
    wait_ps(0);
    repeat (4) step();
    enable = 1'b0;
    repeat (6) step();
    enable = 1'b1;
    repeat (5) step();
    check("resume_busy", 32'(busy_a), 32'd1);
    step();
    check("resume_ps", 32'(ps_a), 32'd1);

    // Enable re-asserted on the wrap edge
    enable = 1'b0;
    repeat (15) step();
    enable = 1'b1;
    duty   = 4'd9;
    step();
    check("simul_ps", 32'(ps_a), 32'd1);
    check("simul_busy", 32'(busy_a), 32'd1);
    count_high(0, 16, h);
    check("simul_duty", 32'(h), 32'd9);

    // Reset mid-period with duty_q=12
    duty = 4'd12;
    count_high(0, 16, h);
    check("mid_ps", 32'(ps_a), 32'd1);
    repeat (9) step();
    check("mid_pwm_hi", 32'(pwm_a), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_pwm", 32'(pwm_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_ps", 32'(ps_a), 32'd0);
    reset = 1'b0;
    step();
    check("mid_rel_ps", 32'(ps_a), 32'd1);
    step();
    check("mid_rel_pwm", 32'(pwm_a), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) duty = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_channel.md
Name: pwm_channel

Overview:
Downstream consumer of the rotary-encoder stage. Takes the encoder's 8-bit `value` as a duty-cycle request and drives one LED colour channel of the RGB mixer with a glitch-free PWM waveform. Duty changes are double-buffered and applied only at period boundaries. A run/stop state machine keeps the final period intact when the channel is disabled. Three instances (R, G, B) sit side by side, each fed by its own encoder.

Parameters:
WIDTH, 8, duty/counter width in bits; period is 2^WIDTH counter steps.
DIV, 1, prescaler divisor; the counter advances once every DIV clk cycles; legal range DIV >= 1.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  level; 1 = run the channel, 0 = stop at the end of the current period
duty  input  WIDTH  requested duty (the encoder `value`); sampled only at period boundaries
pwm_out  output  1  registered PWM waveform
period_start  output  1  one-cycle pulse marking the first cycle of each new period
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (clk edge with reset=1, overrides everything, including mid-period):
  - state=IDLE, cnt=0, pre=0, duty_q=0.
  - pwm_out=0, period_start=0; busy=0 follows from state.
- States: IDLE, RUN, STOP. busy = (state != IDLE), combinational from state.
- IDLE:
  - cnt=0, pre=0, pwm_out forced 0.
  - On an edge with enable=1: state<=RUN, duty_q<=duty, cnt<=0, pre<=0, period_start<=1.
- Prescaler (RUN and STOP):
  - pre counts 0..DIV-1; tick = (pre == DIV-1); on tick pre<=0.
  - DIV=1 gives tick every cycle.
- Counter: on tick, cnt<=cnt+1, wrapping from 2^WIDTH-1 to 0. Wrap event = tick && cnt == 2^WIDTH-1.
- pwm_out:
  - Registered: pwm_out <= (state != IDLE) && (cnt < duty_q).
  - It therefore lags cnt by exactly one clk.
  - duty_q=0 gives a constant 0; duty_q=2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH steps (never 100%).
- Wrap event in RUN: duty_q<=duty (shadow load), period_start<=1 on the next cycle, state stays RUN.
- RUN with enable=0: state<=STOP; counting continues unchanged and pwm_out continues to follow duty_q.
- STOP:
  - enable=1 before the wrap: state<=RUN with no disturbance to cnt, pre or duty_q.
  - Wrap while still enable=0: state<=IDLE, cnt<=0, pre<=0, no period_start, no shadow load; pwm_out is 0 from the following cycle.
  - Wrap and enable=1 on the same edge: treated as a RUN wrap (shadow load, period_start, state=RUN).
- period_start is high for exactly one clk per period; it is never asserted in IDLE or on the STOP->IDLE transition.
- duty changes mid-period have no effect until the next wrap, so there are no runt pulses.
- Width rules: cnt and duty_q are WIDTH bits; pre is clog2(DIV) bits, minimum 1. All comparisons are unsigned.

Decomposition:
- Shared package rgb_pkg:
  - PWM_WIDTH = 8, matching the encoder `value` width.
  - PWM_DIV default.
  - State encoding constants ST_IDLE, ST_RUN, ST_STOP.
- One natural sub-module: pwm_prescaler.
  - Inputs: clk, reset, clear, run.
  - Output: tick.
  - Parameterised by DIV.
  - Instantiated once per channel.

Test Plan:
1. WIDTH=4, DIV=1, duty=5, enable=1 held from cycle 0:
   - period_start high at cycle 1 and every 16 cycles after.
   - pwm_out high for 5 consecutive cycles starting cycle 2, low for 11; repeating.
2. WIDTH=4, DIV=2, duty=0 then duty=15:
   - duty=0 gives pwm_out constant 0 across a 32-cycle period.
   - duty=15 gives 30 high / 2 low cycles per period.
3. Shadow update: duty=3 running; change duty to 12 at cnt=7.
   - The current period still shows 3 high steps.
   - The next period, after the period_start pulse, shows 12 high steps.
4. Graceful stop: enable drops at cnt=4.
   - busy stays 1 and the waveform continues to cnt=15.
   - IDLE on the wrap; pwm_out=0 and busy=0 afterwards; no period_start.
   - Variant: re-raise enable at cnt=10; the period continues uninterrupted, then a normal wrap with period_start.
5. Reset mid-period (cnt=9, pwm_out=1, duty_q=12):
   - Next cycle: pwm_out=0, busy=0, period_start=0, cnt=0.
   - With enable still 1 after reset release: period_start on the following edge, fresh period from cnt=0.
6. Simultaneous wrap and enable re-assert in STOP:
   - Channel stays RUN, duty_q loads the new duty, period_start pulses once.
   - No extra idle cycle appears in pwm_out.
